// File: rtl/internal_register_file_pkg.sv
// Shared types for the parametrised register file.
// Holds the clear-sequencer state enum and a DEPTH helper.
package internal_register_pkg;

  typedef enum logic {
    IDLE,
    CLEAR
  } clr_state_e;

  function automatic int depth_of(input int aw);
    return 1 << aw;
  endfunction

endpackage

// File: rtl/internal_register_file_if.sv
// Decoder/ALU-side bus of the register file.
// master drives enable/write/read/clear; slave returns ra/rb/out_valid/busy.
interface internal_register_file_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3
);
  logic              enable;
  logic              wr_en;
  logic [ADDR_W-1:0] rd_adrs;
  logic [DATA_W-1:0] data_in;
  logic              rd_en;
  logic [ADDR_W-1:0] ra_adrs;
  logic [ADDR_W-1:0] rb_adrs;
  logic              clear_start;
  logic [DATA_W-1:0] ra_out;
  logic [DATA_W-1:0] rb_out;
  logic              out_valid;
  logic              busy;

  modport master (
    output enable, wr_en, rd_adrs, data_in,
    output rd_en, ra_adrs, rb_adrs, clear_start,
    input  ra_out, rb_out, out_valid, busy
  );

  modport slave (
    input  enable, wr_en, rd_adrs, data_in,
    input  rd_en, ra_adrs, rb_adrs, clear_start,
    output ra_out, rb_out, out_valid, busy
  );
endinterface

// File: rtl/internal_register_file_clear_ctrl.sv
// Bulk-clear sequencer: IDLE/CLEAR FSM, address counter, busy flop.
// Ports: clock, reset_n, enable, clear_start in; busy, clr_we, clr_adrs out.
module reg_clear_ctrl
  import internal_register_pkg::*;
#(
  parameter int ADDR_W = 3
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              enable,
  input  logic              clear_start,
  output logic              busy,
  output logic              clr_we,
  output logic [ADDR_W-1:0] clr_adrs
);

  localparam int DEPTH = depth_of(ADDR_W);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  clr_state_e        state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              busy_q, busy_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (enable) begin
      unique case (state_q)
        IDLE: begin
          if (clear_start) begin
            state_d = CLEAR;
            cnt_d   = '0;
          end
        end
        CLEAR: begin
          cnt_d = cnt_q + ADDR_W'(1);
          if (cnt_q == LAST) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
    busy_d = (state_d == CLEAR);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
    end
  end

  assign busy     = busy_q;
  assign clr_we   = enable && (state_q == CLEAR);
  assign clr_adrs = cnt_q;

endmodule

// File: rtl/internal_register_file.sv
// Register file: one write port, two registered read ports, bulk clear.
// Ports: clock, reset_n, bus (slave: write/read/clear in, ra/rb/valid/busy out).
module internal_register_file
  import internal_register_pkg::*;
#(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 3,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 0
) (
  input  logic                      clock,
  input  logic                      reset_n,
  internal_register_file_if.slave   bus
);

  localparam int DEPTH = depth_of(ADDR_W);

  logic [DATA_W-1:0] regs_q [DEPTH];
  logic [DATA_W-1:0] regs_d [DEPTH];
  logic [DATA_W-1:0] ra_q, ra_d;
  logic [DATA_W-1:0] rb_q, rb_d;
  logic              valid_q, valid_d;
  logic              busy;
  logic              clr_we;
  logic [ADDR_W-1:0] clr_adrs;
  logic              acc;

  reg_clear_ctrl #(.ADDR_W(ADDR_W)) u_clr (
    .clock       (clock),
    .reset_n     (reset_n),
    .enable      (bus.enable),
    .clear_start (bus.clear_start),
    .busy        (busy),
    .clr_we      (clr_we),
    .clr_adrs    (clr_adrs)
  );

  // Read value seen in the current cycle, including write bypass.
  function automatic logic [DATA_W-1:0] value_of(
    input logic [ADDR_W-1:0] x,
    input logic [DATA_W-1:0] stored
  );
    if (ZERO_REG != 0 && x == '0) return '0;
    if (BYPASS != 0 && bus.wr_en && x == bus.rd_adrs)
      return bus.data_in;
    return stored;
  endfunction

  assign acc = bus.enable && !busy;

  always_comb begin
    regs_d  = regs_q;
    ra_d    = ra_q;
    rb_d    = rb_q;
    valid_d = 1'b0;
    if (clr_we) begin
      regs_d[clr_adrs] = '0;
    end else if (acc && bus.wr_en &&
                 !(ZERO_REG != 0 && bus.rd_adrs == '0)) begin
      regs_d[bus.rd_adrs] = bus.data_in;
    end
    if (acc && bus.rd_en) begin
      ra_d    = value_of(bus.ra_adrs, regs_q[bus.ra_adrs]);
      rb_d    = value_of(bus.rb_adrs, regs_q[bus.rb_adrs]);
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) regs_q[i] <= '0;
      ra_q    <= '0;
      rb_q    <= '0;
      valid_q <= 1'b0;
    end else begin
      regs_q  <= regs_d;
      ra_q    <= ra_d;
      rb_q    <= rb_d;
      valid_q <= valid_d;
    end
  end

  assign bus.ra_out    = ra_q;
  assign bus.rb_out    = rb_q;
  assign bus.out_valid = valid_q;
  assign bus.busy      = busy;

endmodule

// File: tb/tb_internal_register_file.sv
// Randomised + directed bench for three register-file configurations
// (bypass, no bypass, bypass with hardwired zero) against one reference model.
module tb_internal_register_file;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en, we, re, cs;
  logic [2:0]  wa, ra, rb;
  logic [15:0] din;

  always #5 clk = ~clk;

  internal_register_file_if #(.DATA_W(16), .ADDR_W(3)) bus0 ();
  internal_register_file_if #(.DATA_W(16), .ADDR_W(3)) bus1 ();
  internal_register_file_if #(.DATA_W(16), .ADDR_W(3)) bus2 ();

  internal_register_file #(.DATA_W(16), .ADDR_W(3), .BYPASS(1), .ZERO_REG(0))
    u_dut0 (.clock(clk), .reset_n(rst_n), .bus(bus0));
  internal_register_file #(.DATA_W(16), .ADDR_W(3), .BYPASS(0), .ZERO_REG(0))
    u_dut1 (.clock(clk), .reset_n(rst_n), .bus(bus1));
  internal_register_file #(.DATA_W(16), .ADDR_W(3), .BYPASS(1), .ZERO_REG(1))
    u_dut2 (.clock(clk), .reset_n(rst_n), .bus(bus2));

  assign bus0.enable = en;  assign bus1.enable = en;  assign bus2.enable = en;
  assign bus0.wr_en = we;   assign bus1.wr_en = we;   assign bus2.wr_en = we;
  assign bus0.rd_adrs = wa; assign bus1.rd_adrs = wa; assign bus2.rd_adrs = wa;
  assign bus0.data_in = din; assign bus1.data_in = din; assign bus2.data_in = din;
  assign bus0.rd_en = re;   assign bus1.rd_en = re;   assign bus2.rd_en = re;
  assign bus0.ra_adrs = ra; assign bus1.ra_adrs = ra; assign bus2.ra_adrs = ra;
  assign bus0.rb_adrs = rb; assign bus1.rb_adrs = rb; assign bus2.rb_adrs = rb;
  assign bus0.clear_start = cs;
  assign bus1.clear_start = cs;
  assign bus2.clear_start = cs;

  logic [15:0] ra_a [3];
  logic [15:0] rb_a [3];
  logic        ov_a [3];
  logic        bz_a [3];
  assign ra_a[0] = bus0.ra_out; assign ra_a[1] = bus1.ra_out;
  assign ra_a[2] = bus2.ra_out;
  assign rb_a[0] = bus0.rb_out; assign rb_a[1] = bus1.rb_out;
  assign rb_a[2] = bus2.rb_out;
  assign ov_a[0] = bus0.out_valid; assign ov_a[1] = bus1.out_valid;
  assign ov_a[2] = bus2.out_valid;
  assign bz_a[0] = bus0.busy; assign bz_a[1] = bus1.busy;
  assign bz_a[2] = bus2.busy;

  // Reference model
  bit          bp [3] = '{1'b1, 1'b0, 1'b1};
  bit          zr [3] = '{1'b0, 1'b0, 1'b1};
  logic [15:0] mem [3][8];
  logic [15:0] ra_e [3];
  logic [15:0] rb_e [3];
  logic        ov_e [3];
  bit          clearing;
  int          clr_idx;

  int pass_n = 0;
  int total_n = 0;

  task automatic chk(input string name, input int c,
                     input logic [15:0] act, input logic [15:0] exp);
    total_n++;
    if (act === exp) pass_n++;
    else $display("FAIL %s cfg%0d got %h expected %h @%0t",
                  name, c, act, exp, $time);
  endtask

  task automatic model_reset();
    for (int c = 0; c < 3; c++) begin
      for (int i = 0; i < 8; i++) mem[c][i] = '0;
      ra_e[c] = '0; rb_e[c] = '0; ov_e[c] = 1'b0;
    end
    clearing = 1'b0;
    clr_idx = 0;
  endtask

  function automatic logic [15:0] mval(input int c, input logic [2:0] x);
    if (zr[c] && x == 3'd0) return 16'h0000;
    if (bp[c] && we && x == wa) return din;
    return mem[c][x];
  endfunction

  task automatic model_step();
    if (!en) begin
      for (int c = 0; c < 3; c++) ov_e[c] = 1'b0;
      return;
    end
    if (clearing) begin
      for (int c = 0; c < 3; c++) begin
        mem[c][clr_idx] = '0;
        ov_e[c] = 1'b0;
      end
      clr_idx++;
      if (clr_idx == 8) clearing = 1'b0;
      return;
    end
    for (int c = 0; c < 3; c++) begin
      if (re) begin
        ra_e[c] = mval(c, ra);
        rb_e[c] = mval(c, rb);
        ov_e[c] = 1'b1;
      end else begin
        ov_e[c] = 1'b0;
      end
    end
    for (int c = 0; c < 3; c++)
      if (we && !(zr[c] && wa == 3'd0)) mem[c][wa] = din;
    if (cs) begin
      clearing = 1'b1;
      clr_idx = 0;
    end
  endtask

  task automatic compare();
    for (int c = 0; c < 3; c++) begin
      chk("ra_out", c, ra_a[c], ra_e[c]);
      chk("rb_out", c, rb_a[c], rb_e[c]);
      chk("out_valid", c, 16'(ov_a[c]), 16'(ov_e[c]));
      chk("busy", c, 16'(bz_a[c]), 16'(clearing));
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    @(negedge clk);
    compare();
  endtask

  task automatic idle_in();
    en = 1'b1; we = 1'b0; re = 1'b0; cs = 1'b0;
  endtask

  task automatic load_all();
    idle_in();
    for (int i = 0; i < 8; i++) begin
      we = 1'b1; wa = 3'(i); din = 16'h1111 * 16'(i + 1);
      tick();
    end
    idle_in();
  endtask

  task automatic async_reset();
    rst_n = 1'b0;
    #2;
    model_reset();
    compare();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  int bcnt;

  initial begin
    idle_in();
    wa = '0; ra = '0; rb = '0; din = '0;
    model_reset();
    repeat (2) @(negedge clk);
    compare();
    rst_n = 1'b1;

    // read after reset
    re = 1'b1; ra = 3'd3; rb = 3'd7;
    tick();
    chk("lit_rst_ra", 0, ra_a[0], 16'h0000);
    chk("lit_rst_rb", 0, rb_a[0], 16'h0000);
    chk("lit_rst_ov", 0, 16'(ov_a[0]), 16'h0001);
    chk("lit_rst_busy", 0, 16'(bz_a[0]), 16'h0000);

    // write then read same reg on both ports
    idle_in(); we = 1'b1; wa = 3'd5; din = 16'hBEEF;
    tick();
    idle_in(); re = 1'b1; ra = 3'd5; rb = 3'd5;
    tick();
    chk("lit_rd5_a", 0, ra_a[0], 16'hBEEF);
    chk("lit_rd5_b", 0, rb_a[0], 16'hBEEF);

    // same-cycle write/read of reg 2
    idle_in(); we = 1'b1; wa = 3'd2; din = 16'hBEEF;
    tick();
    we = 1'b1; wa = 3'd2; din = 16'h1234; re = 1'b1; ra = 3'd2; rb = 3'd5;
    tick();
    chk("lit_bypass", 0, ra_a[0], 16'h1234);
    chk("lit_nobypass", 1, ra_a[1], 16'hBEEF);

    // hardwired zero register
    idle_in(); we = 1'b1; wa = 3'd0; din = 16'hFFFF;
    tick();
    idle_in(); re = 1'b1; ra = 3'd0; rb = 3'd0;
    tick();
    chk("lit_zero_ra", 2, ra_a[2], 16'h0000);
    chk("lit_nozero_ra", 0, ra_a[0], 16'hFFFF);
    idle_in(); we = 1'b1; wa = 3'd1; din = 16'h5A5A;
    tick();
    idle_in(); re = 1'b1; ra = 3'd1; rb = 3'd0;
    tick();
    chk("lit_zero_r1", 2, ra_a[2], 16'h5A5A);

    // bulk clear with traffic ignored while busy
    load_all();
    cs = 1'b1;
    tick();
    bcnt = 0;
    for (int k = 0; k < 20; k++) begin
      if (!bz_a[0]) break;
      bcnt++;
      cs = 1'($urandom_range(1)); we = 1'b1; wa = 3'($urandom_range(7));
      din = 16'($urandom); re = 1'b1;
      ra = 3'($urandom_range(7)); rb = 3'($urandom_range(7));
      chk("lit_clr_ov", 0, 16'(ov_a[0]), 16'h0000);
      tick();
    end
    chk("lit_busy_len", 0, 16'(bcnt), 16'd8);
    idle_in();
    for (int i = 0; i < 8; i++) begin
      re = 1'b1; ra = 3'(i); rb = 3'(7 - i);
      tick();
      chk("lit_cleared", 0, ra_a[0], 16'h0000);
    end

    // enable dropped for 3 cycles mid-clear
    load_all();
    cs = 1'b1;
    tick();
    cs = 1'b0;
    bcnt = 1;
    for (int k = 0; k < 30; k++) begin
      en = (k < 2 || k > 4);
      tick();
      if (!bz_a[0]) break;
      bcnt++;
    end
    chk("lit_busy_stall", 0, 16'(bcnt), 16'd11);
    idle_in();

    // async reset at clear step 4
    load_all();
    cs = 1'b1;
    tick();
    cs = 1'b0;
    repeat (3) tick();
    chk("lit_busy_pre", 0, 16'(bz_a[0]), 16'h0001);
    async_reset();
    chk("lit_rst_mid_busy", 0, 16'(bz_a[0]), 16'h0000);
    chk("lit_rst_mid_ra", 0, ra_a[0], 16'h0000);
    for (int i = 0; i < 8; i++) begin
      re = 1'b1; ra = 3'(i); rb = 3'(i);
      tick();
    end

    // random traffic
    for (int n = 0; n < 600; n++) begin
      en  = ($urandom_range(9) != 0);
      we  = 1'($urandom_range(1));
      re  = ($urandom_range(9) < 6);
      cs  = ($urandom_range(49) == 0);
      wa  = 3'($urandom_range(7));
      ra  = ($urandom_range(3) == 0) ? wa : 3'($urandom_range(7));
      rb  = 3'($urandom_range(7));
      din = 16'($urandom);
      if ($urandom_range(199) == 0) async_reset();
      else tick();
    end

    $display("%0d/%0d checks passed", pass_n, total_n);
    $finish;
  end

endmodule

// File: doc/internal_register_file.md
Name: internal_register_file

Overview:
Parametrised successor to the team's 8x16 internal register block. It provides a configurable-width, configurable-depth register file with one write port and two registered read ports. Unlike the earlier block, reads and writes can happen in the same cycle, with optional write-to-read bypass. It adds an optional hardwired-zero register and a sequenced bulk-clear engine with a busy handshake. It sits between the instruction decoder (addresses) and the ALU operand latches (ra_out/rb_out).

Parameters:
DATA_W, 16, register and data-path width in bits
ADDR_W, 3, address width; DEPTH = 2**ADDR_W registers
BYPASS, 1, 1 = a read of the address being written in the same cycle returns data_in; 0 = returns the old contents
ZERO_REG, 0, 1 = register 0 always reads 0 and writes to it are dropped

Ports:
clock  input  1  single clock, all state updates on rising edge
reset_n  input  1  asynchronous, active-low reset
enable  input  1  global advance; low freezes all state, including the clear sequence
wr_en  input  1  write strobe
rd_adrs  input  ADDR_W  write (destination) address
data_in  input  DATA_W  write data
rd_en  input  1  read strobe for both read ports
ra_adrs  input  ADDR_W  read port A address
rb_adrs  input  ADDR_W  read port B address
clear_start  input  1  request bulk clear of all registers
ra_out  output  DATA_W  registered read data, port A
rb_out  output  DATA_W  registered read data, port B
out_valid  output  1  ra_out/rb_out updated by a read in the previous cycle
busy  output  1  clear sequence in progress

Behaviour:
- Reset (reset_n low, asynchronous):
  - All DEPTH registers = 0.
  - ra_out = rb_out = 0; out_valid = 0; busy = 0.
  - FSM = IDLE; clear counter = 0.
  - Releasing reset mid-clear leaves the block in IDLE with a fully zeroed array.
- enable low: no register, output, counter or state changes; out_valid forced to 0 on that edge.
- FSM states: IDLE, CLEAR.
  - IDLE -> CLEAR on an edge with enable && clear_start; counter <= 0.
  - CLEAR: on each enabled edge, reg[counter] <= 0 and counter increments.
  - On the edge where counter == DEPTH-1, FSM -> IDLE.
  - Clear therefore takes exactly DEPTH enabled cycles.
  - busy = (state == CLEAR), registered.
- During CLEAR:
  - wr_en and rd_en are ignored.
  - ra_out/rb_out hold; out_valid = 0.
  - clear_start is ignored (no restart).
- IDLE write: on an enabled edge with wr_en, reg[rd_adrs] <= data_in. Dropped if ZERO_REG && rd_adrs == 0.
- IDLE read:
  - On an enabled edge with rd_en, ra_out <= value(ra_adrs) and rb_out <= value(rb_adrs); out_valid <= 1.
  - Latency: 1 cycle from address to output.
  - If rd_en is low, outputs hold and out_valid <= 0.
- value(x):
  - 0 if ZERO_REG && x == 0.
  - Otherwise data_in if BYPASS && wr_en && x == rd_adrs.
  - Otherwise reg[x].
- Both ports may read the same address; both receive the same value.
- clear_start with wr_en in the same IDLE cycle: the write and any read complete normally; CLEAR begins on the next cycle and zeroes the written register.
- Addresses wrap naturally at DEPTH; there are no out-of-range addresses.
- No arithmetic on data; all widths are exact DATA_W.

Decomposition:
- Package internal_register_pkg:
  - state enum {IDLE, CLEAR}
  - helper function for DEPTH from ADDR_W
- Sub-module reg_clear_ctrl:
  - Contains the FSM, the clear counter and the busy register.
  - Outputs clr_we and clr_adrs, which the top muxes onto the array write port (the clear path takes priority).
- The storage array and read muxes stay in the top module.

Test Plan:
(DATA_W=16, ADDR_W=3 unless stated)
- Reset, then read ra=3, rb=7 -> next cycle ra_out=0x0000, rb_out=0x0000, out_valid=1; busy=0 throughout.
- Write 0xBEEF to reg 5, next cycle read ra=5, rb=5 -> ra_out=rb_out=0xBEEF one cycle after rd_en.
- Same cycle: write 0x1234 to reg 2, read ra=2.
  - BYPASS=1 -> ra_out=0x1234.
  - BYPASS=0 -> ra_out = prior value 0xBEEF (preloaded).
- ZERO_REG=1: write 0xFFFF to reg 0, read ra=0 -> 0x0000; write to reg 1 and read it back unaffected.
- Load regs 0-7 with 0x1111..0x8888, pulse clear_start:
  - busy high for exactly 8 cycles.
  - Writes and reads during busy are ignored; out_valid=0.
  - Afterwards all registers read 0.
- Mid-clear, drop enable for 3 cycles -> counter and busy freeze and clear completes 3 cycles later; assert reset_n low at clear step 4 -> immediate busy=0, outputs 0, all registers read 0 after release.
